call_stack: RTL

- Hardware return-address stack sitting directly upstream of the program counter.
- Captures the return address on a call, then presents the top entry on DoST so the PC can load it when Ret is asserted.
- Pops on return, and reports occupancy and error status to the control unit.
- Storage is a register file. The top-of-stack read path is combinational, so DoST is stable well before the PC's capture edge.

---
 rtl/call_stack.sv | 101 ++++++++++
 1 files changed

// File: rtl/call_stack.sv
// Return-address stack feeding the program counter: circular register file with a
// combinational top-of-stack read, saturating occupancy count and sticky error flags.
module call_stack #(
    parameter int DEPTH = 16,   // power of two, 2..64
    parameter int AW    = 16
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       push,
    input  logic                       pop,
    input  logic [AW-1:0]              RetAddr,
    input  logic                       clr_err,
    output logic [AW-1:0]              DoST,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int SPW = $clog2(DEPTH);
    localparam int CW  = SPW + 1;

    logic [AW-1:0]  r_mem [DEPTH];
    logic [SPW-1:0] r_sp;
    logic [CW-1:0]  r_count;
    logic           r_overflow;
    logic           r_underflow;

    logic           w_empty;
    logic           w_full;
    logic [SPW-1:0] w_top_idx;
    logic           w_do_push;
    logic           w_do_pop;
    logic           w_replace;
    logic           w_wr_en;
    logic [SPW-1:0] w_wr_idx;
    logic           w_ovf_evt;
    logic           w_unf_evt;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CW'(DEPTH));
    assign w_top_idx = r_sp - SPW'(1);

    // Push+pop on a non-empty stack is a tail call (replace top); on an empty
    // stack it degenerates to a plain push with no underflow.
    assign w_replace = push & pop & ~w_empty;
    assign w_do_push = push & ~w_replace;
    assign w_do_pop  = pop & ~push & ~w_empty;
    assign w_wr_en   = w_do_push | w_replace;
    assign w_wr_idx  = w_replace ? w_top_idx : r_sp;
    assign w_ovf_evt = w_do_push & w_full;
    assign w_unf_evt = pop & ~push & w_empty;

    // Storage carries no reset; contents are irrelevant while count is zero.
    always_ff @(posedge CLK) begin
        if (!RST && w_wr_en) begin
            r_mem[w_wr_idx] <= RetAddr;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sp        <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_do_push) begin
                r_sp <= r_sp + SPW'(1);
                if (!w_full) begin
                    r_count <= r_count + CW'(1);
                end
            end else if (w_do_pop) begin
                r_sp    <= r_sp - SPW'(1);
                r_count <= r_count - CW'(1);
            end

            // A new error event beats a simultaneous clear.
            if (w_ovf_evt) begin
                r_overflow <= 1'b1;
            end else if (clr_err) begin
                r_overflow <= 1'b0;
            end

            if (w_unf_evt) begin
                r_underflow <= 1'b1;
            end else if (clr_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign DoST      = w_empty ? '0 : r_mem[w_top_idx];
    assign empty     = w_empty;
    assign full      = w_full;
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule
